// File: rtl/ascon_byte_loader.sv
// ascon_byte_loader
// -----------------
// Byte-serial front end for the Ascon core. A header byte is taken in IDLE.
// Its fields are [7:6] opcode, [5:4] register index and [2:0] mode.
//   opcode 00 LOAD : the next 16 bytes are shifted into a shadow register.
//                    The shadow is then committed atomically to reg<idx>.
//   opcode 01 START: mode is latched and a one-cycle start pulse is issued.
//                    Input is then locked out for LOCK_CYCLES cycles.
//   opcode 10 NOP  : accepted, no effect.
//   opcode 11      : reserved; sets the sticky error flag.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   byte_valid/ready  8-bit input stream handshake (transfer = valid & ready)
//   byte_data         header or data byte
//   reg0/1/2_128b     committed operand registers
//   operation_mode    mode latched by the last accepted START header
//   operation_ready   one-cycle start pulse to the core
//   load_done         one-cycle pulse when an operand register is committed
//   err               sticky protocol error flag
module ascon_byte_loader #(
  parameter int unsigned LOCK_CYCLES = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  output logic [127:0] reg0_128b,
  output logic [127:0] reg1_128b,
  output logic [127:0] reg2_128b,
  output logic [2:0]   operation_mode,
  output logic         operation_ready,
  output logic         load_done,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, LOAD, START, LOCK} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_START, OP_NOP, OP_RSVD} opcode_t;

  localparam logic [7:0] LOCK_INIT = 8'(LOCK_CYCLES);

  state_t       state, state_nx;
  logic [127:0] shadow;
  logic [127:0] shadow_nx;
  logic [3:0]   byte_cnt;
  logic [1:0]   target;
  logic [7:0]   lock_cnt;

  logic         xfer;
  opcode_t      hdr_op;
  logic [1:0]   hdr_idx;
  logic [2:0]   hdr_mode;
  logic         idx_ok;
  logic         mode_ok;
  logic         last_byte;

  assign xfer      = byte_valid & byte_ready;
  assign hdr_op    = opcode_t'(byte_data[7:6]);
  assign hdr_idx   = byte_data[5:4];
  assign hdr_mode  = byte_data[2:0];
  assign idx_ok    = (hdr_idx != 2'd3);
  assign mode_ok   = (hdr_mode < 3'd6);
  assign shadow_nx = {shadow[119:0], byte_data};
  assign last_byte = (byte_cnt == 4'd15);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (hdr_op == OP_LOAD && idx_ok)
            state_nx = LOAD;
          else if (hdr_op == OP_START && mode_ok)
            state_nx = START;
        end
      end
      LOAD:  if (xfer && last_byte) state_nx = IDLE;
      START: state_nx = (LOCK_CYCLES == 0) ? IDLE : LOCK;
      // The counter holds LOCK_CYCLES on entry, so LOCK lasts exactly that many cycles.
      LOCK:  if (lock_cnt <= 8'd1) state_nx = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    byte_ready      = (state == IDLE) || (state == LOAD);
    operation_ready = (state == START);
  end

  // Datapath: header decode, byte assembly, commit and lock counter
  always_ff @(posedge clk) begin
    if (rst) begin
      reg0_128b      <= '0;
      reg1_128b      <= '0;
      reg2_128b      <= '0;
      shadow         <= '0;
      byte_cnt       <= '0;
      target         <= '0;
      operation_mode <= '0;
      load_done      <= 1'b0;
      err            <= 1'b0;
      lock_cnt       <= '0;
    end else begin
      load_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            unique case (hdr_op)
              OP_LOAD: begin
                if (idx_ok) begin
                  target   <= hdr_idx;
                  byte_cnt <= '0;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_START: begin
                if (mode_ok) operation_mode <= hdr_mode;
                else         err            <= 1'b1;
              end
              OP_NOP:  ;
              OP_RSVD: err <= 1'b1;
            endcase
          end
        end
        LOAD: begin
          if (xfer) begin
            shadow   <= shadow_nx;
            byte_cnt <= byte_cnt + 4'd1;
            // Commit from the shifted value so the last byte lands in the same edge.
            if (last_byte) begin
              unique case (target)
                2'd0:    reg0_128b <= shadow_nx;
                2'd1:    reg1_128b <= shadow_nx;
                2'd2:    reg2_128b <= shadow_nx;
                default: ;
              endcase
              load_done <= 1'b1;
            end
          end
        end
        START: lock_cnt <= LOCK_INIT;
        LOCK:  lock_cnt <= lock_cnt - 8'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_byte_loader.sv
module tb_ascon_byte_loader;

  localparam int unsigned LOCK = 48;

  logic         clk;
  logic         rst;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic [127:0] reg0_128b, reg1_128b, reg2_128b;
  logic [2:0]   operation_mode;
  logic         operation_ready, load_done, err;

  // Second instance built with a zero lockout
  logic         rst0, v0;
  logic [7:0]   d0;
  logic         ready0;
  logic [127:0] r0_0, r1_0, r2_0;
  logic [2:0]   mode0;
  logic         opr0, ld0, err0;

  int n_tests = 0;
  int n_fail  = 0;

  ascon_byte_loader #(.LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reg0_128b(reg0_128b), .reg1_128b(reg1_128b),
    .reg2_128b(reg2_128b), .operation_mode(operation_mode),
    .operation_ready(operation_ready), .load_done(load_done), .err(err)
  );

  ascon_byte_loader #(.LOCK_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .byte_valid(v0), .byte_data(d0),
    .byte_ready(ready0), .reg0_128b(r0_0), .reg1_128b(r1_0),
    .reg2_128b(r2_0), .operation_mode(mode0),
    .operation_ready(opr0), .load_done(ld0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks the stream at transaction level: a queue of collected data bytes,
  // and a count of how many more cycles input is refused.
  logic [127:0] m_reg [3];
  logic [2:0]   m_mode;
  logic         m_opr, m_ld, m_err;
  int           m_hold;
  bit           m_loading;
  int           m_tgt;
  logic [7:0]   m_q [$];

  always begin
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) m_reg[i] = '0;
      m_mode = '0; m_opr = 0; m_ld = 0; m_err = 0;
      m_hold = 0; m_loading = 0; m_tgt = 0; m_q.delete();
    end else begin
      automatic bit acc = byte_valid && (m_hold == 0);
      automatic logic [7:0] d = byte_data;
      m_opr = 0;
      m_ld  = 0;
      if (m_hold > 0) m_hold--;
      if (acc) begin
        if (m_loading) begin
          m_q.push_back(d);
          if (m_q.size() == 16) begin
            automatic logic [127:0] val = '0;
            for (int i = 0; i < 16; i++) val[127-8*i -: 8] = m_q[i];
            m_reg[m_tgt] = val;
            m_ld = 1;
            m_loading = 0;
          end
        end else begin
          case (d[7:6])
            2'b00: if (d[5:4] != 2'd3) begin
                     m_loading = 1; m_tgt = int'(d[5:4]); m_q.delete();
                   end else m_err = 1;
            2'b01: if (d[2:0] < 3'd6) begin
                     m_mode = d[2:0]; m_opr = 1; m_hold = 1 + LOCK;
                   end else m_err = 1;
            2'b10: ;
            default: m_err = 1;
          endcase
        end
      end
    end
    #1;
    check("mdl_reg0",  reg0_128b, m_reg[0]);
    check("mdl_reg1",  reg1_128b, m_reg[1]);
    check("mdl_reg2",  reg2_128b, m_reg[2]);
    check("mdl_mode",  operation_mode, m_mode);
    check("mdl_opr",   operation_ready, m_opr);
    check("mdl_ld",    load_done, m_ld);
    check("mdl_err",   err, m_err);
    check("mdl_ready", byte_ready, m_hold == 0);
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    byte_valid = v;
    byte_data  = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; byte_valid = 0; byte_data = '0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!byte_ready && n < 200) begin
      after_edge();
      n++;
    end
    check(name, byte_ready, 1'b1);
  endtask

  typedef struct {
    logic [7:0] hdr;
    logic       e_err;
    logic       e_opr;
    logic [2:0] e_mode;
    logic       e_ready;
  } hdr_vec_t;

  hdr_vec_t vecs [7];

  initial begin
    vecs[0] = '{8'h30, 1'b1, 1'b0, 3'd0, 1'b1};  // LOAD idx3
    vecs[1] = '{8'hC0, 1'b1, 1'b0, 3'd0, 1'b1};  // reserved
    vecs[2] = '{8'h47, 1'b1, 1'b0, 3'd0, 1'b1};  // START mode 7
    vecs[3] = '{8'h80, 1'b0, 1'b0, 3'd0, 1'b1};  // NOP
    vecs[4] = '{8'h08, 1'b0, 1'b0, 3'd0, 1'b1};  // LOAD idx0, bit3 ignored
    vecs[5] = '{8'h45, 1'b0, 1'b1, 3'd5, 1'b0};  // START mode 5
    vecs[6] = '{8'h4E, 1'b1, 1'b0, 3'd0, 1'b1};  // START mode 6, bit3 set

    rst = 1; byte_valid = 0; byte_data = '0;
    rst0 = 1; v0 = 0; d0 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("reset_ready", byte_ready, 1'b1);
    check("reset_reg0", reg0_128b, '0);
    check("reset_err", err, 1'b0);
    check("reset_opr", operation_ready, 1'b0);

    // Full-rate load of reg0
    drive(1, 8'h00);
    after_edge();
    check("t1_hdr_ready", byte_ready, 1'b1);
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(i));
      after_edge();
      check("t1_ready", byte_ready, 1'b1);
      if (i < 15) check("t1_no_ld", load_done, 1'b0);
    end
    check("t1_reg0", reg0_128b, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_ld", load_done, 1'b1);
    check("t1_reg1", reg1_128b, '0);
    check("t1_reg2", reg2_128b, '0);
    drive(0, 8'h00);
    after_edge();
    check("t1_ld_off", load_done, 1'b0);

    // reg2 load with valid toggling every cycle
    drive(1, 8'h20);
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) drive(1, 8'hFF);
      else            drive(0, 8'h00);
      after_edge();
      if (i < 30) check("t2_reg2_hold", reg2_128b, '0);
      else if (i == 30) begin
        check("t2_reg2", reg2_128b, {128{1'b1}});
        check("t2_ld", load_done, 1'b1);
      end
    end

    // START with lockout; bytes offered during lock must not be consumed
    drive(1, 8'h41);
    after_edge();
    check("t3_opr", operation_ready, 1'b1);
    check("t3_mode", operation_mode, 3'd1);
    check("t3_ready_start", byte_ready, 1'b0);
    begin
      int low = 1;
      drive(1, 8'h00);
      for (int n = 0; n < 200; n++) begin
        after_edge();
        if (byte_ready) break;
        check("t3_opr_lock", operation_ready, 1'b0);
        low++;
      end
      byte_valid = 0;
      check("t3_low_cycles", low, LOCK + 1);
    end
    drive(1, 8'h42);
    after_edge();
    check("t3_opr2", operation_ready, 1'b1);
    check("t3_mode2", operation_mode, 3'd2);
    drive(0, 8'h00);
    wait_ready("t3_relock_end");

    // Table of single-header cases, each from reset
    foreach (vecs[k]) begin
      do_reset();
      drive(1, vecs[k].hdr);
      after_edge();
      check($sformatf("t4_err_%h", vecs[k].hdr), err, vecs[k].e_err);
      check($sformatf("t4_opr_%h", vecs[k].hdr), operation_ready, vecs[k].e_opr);
      check($sformatf("t4_mode_%h", vecs[k].hdr), operation_mode, vecs[k].e_mode);
      check($sformatf("t4_ready_%h", vecs[k].hdr), byte_ready, vecs[k].e_ready);
      drive(0, 8'h00);
    end

    // Bad headers after a START keep the mode and never pulse
    do_reset();
    drive(1, 8'h43);
    drive(0, 8'h00);
    wait_ready("t4_lock_end");
    drive(1, 8'h30); after_edge();
    check("t4s_err", err, 1'b1);
    drive(1, 8'hC0); after_edge();
    check("t4s_opr_c0", operation_ready, 1'b0);
    drive(1, 8'h47); after_edge();
    check("t4s_mode", operation_mode, 3'd3);
    check("t4s_opr_47", operation_ready, 1'b0);
    check("t4s_ready", byte_ready, 1'b1);
    drive(0, 8'h00);

    // Reset mid-load, then a clean reload
    do_reset();
    drive(1, 8'h10);
    for (int i = 0; i < 10; i++) drive(1, 8'hAA);
    do_reset();
    #1;
    check("t5_reg0", reg0_128b, '0);
    check("t5_reg1", reg1_128b, '0);
    check("t5_reg2", reg2_128b, '0);
    drive(1, 8'h10);
    for (int i = 0; i < 16; i++) drive(1, 8'(8'h10 + i));
    after_edge();
    check("t5_reg1_new", reg1_128b, 128'h101112131415161718191A1B1C1D1E1F);
    check("t5_ld", load_done, 1'b1);
    drive(0, 8'h00);

    // Zero-lockout instance
    @(negedge clk);
    rst0 = 0; v0 = 1; d0 = 8'h42;
    after_edge();
    check("t6_opr", opr0, 1'b1);
    check("t6_mode", mode0, 3'd2);
    check("t6_ready_start", ready0, 1'b0);
    @(negedge clk);
    d0 = 8'h43;
    after_edge();
    check("t6_ready_back", ready0, 1'b1);
    check("t6_opr_off", opr0, 1'b0);
    after_edge();
    check("t6_opr2", opr0, 1'b1);
    check("t6_mode2", mode0, 3'd3);
    @(negedge clk);
    v0 = 0;

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 299) == 0);
      byte_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: byte_data = 8'h00;
        1: byte_data = 8'h10;
        2: byte_data = 8'h20;
        3: byte_data = 8'h40 | 8'($urandom_range(0, 7));
        4: byte_data = 8'h80;
        default: byte_data = 8'($urandom_range(0, 255));
      endcase
    end
    @(negedge clk);
    rst = 0; byte_valid = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_byte_loader.md
Name: ascon_byte_loader

Overview:
Byte-serial front end that feeds the Ascon core. It assembles the three 128-bit operand registers (key/nonce, plaintext, associated data) from an 8-bit valid/ready stream. It latches the operation mode and issues the single-cycle start pulse the core consumes. It then holds off new input for a fixed lockout while the core runs, so operands stay stable throughout a permutation sequence.

Parameters:
LOCK_CYCLES, 48, cycles byte_ready stays low after a start pulse (covers init plus data/text rounds); 0..255 legal.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
byte_valid  input  1  upstream byte present
byte_data  input  8  header or data byte
byte_ready  output  1  block accepts byte this cycle; transfer = byte_valid & byte_ready
reg0_128b  output  128  operand register 0 (key / init XOR)
reg1_128b  output  128  operand register 1 (nonce / plaintext)
reg2_128b  output  128  operand register 2 (associated data)
operation_mode  output  3  latched mode for core
operation_ready  output  1  one-cycle start pulse to core
load_done  output  1  one-cycle pulse when a 128-bit register is committed
err  output  1  sticky protocol error flag

Behaviour:
- Reset (rst high at an edge): state IDLE; reg0/1/2_128b=0; shadow shift register=0; byte counter=0; operation_mode=0; operation_ready=0; load_done=0; err=0; lock counter=0. Reset mid-load or mid-lock aborts the operation, with no partial commit.
- byte_ready is decoded from state: 1 in IDLE and LOAD, 0 in START and LOCK. Reset value is 1.
- Header byte format (accepted only in IDLE): [7:6] opcode, [5:4] register index, [2:0] mode. Bit 3 is ignored.
- Opcode 00, LOAD:
  - Index 0..2 → latch target, clear byte counter, next state LOAD.
  - Index 3 → err<=1, stay IDLE.
- Opcode 01, START:
  - Mode 0..5 → operation_mode<=mode, next state START.
  - Mode 6/7 → err<=1, stay IDLE, operation_mode unchanged.
- Opcode 10, NOP: accepted, no effect.
- Opcode 11, reserved: err<=1, stay IDLE.
- LOAD state:
  - Each transfer does shadow<={shadow[119:0],byte_data} and counter+=1. The first byte lands at bits [127:120].
  - On the 16th transfer (counter==15 at the accepting edge): the selected reg*_128b<=the new shadow value, atomically, next cycle; the other two registers are unchanged. load_done=1 for one cycle. Counter wraps to 0. Next state IDLE.
  - No partial value is ever visible on reg*_128b.
  - byte_valid low stalls indefinitely; there is no timeout.
- START state lasts exactly 1 cycle:
  - operation_ready=1. It is registered and asserts the cycle after header acceptance.
  - Lock counter<=LOCK_CYCLES.
  - Next state LOCK, or IDLE if LOCK_CYCLES==0.
- LOCK state: counter decrements each cycle. When it reaches 1, next state is IDLE, so byte_ready is low for exactly LOCK_CYCLES cycles after the START cycle.
- Stability: reg*_128b and operation_mode only change on a commit, a START-header acceptance, or reset. They are constant throughout START and LOCK.
- operation_ready and load_done are never high in the same cycle.
- err is sticky until rst. It does not block operation.
- Latencies:
  - Header → operation_ready: 1 cycle.
  - Last data byte → register visible and load_done: 1 cycle.
  - Back-to-back transfers at full rate: 17 cycles per register load (1 header + 16 data bytes).

Test Plan:
1. Reset, then LOAD idx0 header 0x00 and bytes 0x00..0x0F at full rate → reg0_128b=0x000102030405060708090A0B0C0D0E0F one cycle after the 16th byte. load_done pulses once. reg1/reg2 stay 0. byte_ready stays 1 throughout.
2. Load reg2 with 0xFF×16 while toggling byte_valid every other cycle → commit only after the 16th accepted byte. reg2 stays 0 until the commit, then all-ones.
3. START header 0x41 with LOCK_CYCLES=48 → next cycle operation_mode=1 and operation_ready=1 for one cycle. byte_ready=0 for the following 48 cycles, then 1. Bytes offered during lock are not consumed.
4. Header 0x30 (idx3), header 0xC0, and header 0x47 (mode 7) → err=1 after the first. State stays IDLE, operation_mode unchanged, no operation_ready pulse.
5. Load reg1 with 10 bytes, assert rst for one cycle, then do a fresh full load of reg1 → all registers 0 after reset. The subsequent load commits only the new 16 bytes; no stale bytes appear.
6. LOCK_CYCLES=0 build: START header → operation_ready pulses. byte_ready is 0 only during the START cycle, and the next header is accepted the cycle after.
